// File: rtl/ss_entrada.sv
// Operand input stage for the Booth multiplier: synchronises and debounces the
// push-button, latches A/B on each press. Optional: SS_ENTRADA_STICKY_VALID_EN.
module ss_entrada #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             boton,
  output logic             valid,
  output logic [WIDTH-1:0] _A,
  output logic [WIDTH-1:0] _B
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] w_sync_d;
  logic                   w_b_sync;
  logic                   r_db;
  logic [CW-1:0]          r_cnt;
  logic                   w_rise;
  logic                   r_valid;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;

  // Pure wiring into each stage; boton reaches the first flop untouched.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign w_sync_d[gi] = boton;
      end else begin : g_rest
        assign w_sync_d[gi] = r_sync[gi-1];
      end
    end
  endgenerate

  assign w_b_sync = r_sync[SYNC_STAGES-1];

  // A press is the edge where db is about to go 0->1.
  assign w_rise = w_b_sync && !r_db && (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= w_sync_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else if (w_b_sync == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_db  <= w_b_sync;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_rise) begin
        r_a <= A;
        r_b <= B;
      end
`ifdef SS_ENTRADA_STICKY_VALID_EN
      r_valid <= r_valid | w_rise;
`else
      r_valid <= w_rise;
`endif
    end
  end

  assign valid = r_valid;
  assign _A    = r_a;
  assign _B    = r_b;

endmodule

// File: tb/tb_ss_entrada.sv
// Directed bench for ss_entrada: reset, capture latency, glitch rejection,
// hold without retrigger, second press and reset in the middle of a press.
module tb_ss_entrada;

`ifdef SS_ENTRADA_STICKY_VALID_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       boton;
  logic       valid;
  logic [3:0] o_a;
  logic [3:0] o_b;

  int checks = 0;
  int passes = 0;
  bit seen   = 1'b0;

  ss_entrada #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .boton (boton),
    .valid (valid),
    ._A    (o_a),
    ._B    (o_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    $display("t=%0t %s observed=%h expected=%h", $time, tag, obs, exp);
  endtask

  function automatic logic idle_v();
    return STICKY && seen;
  endfunction

  initial begin
    // Reset with all inputs high
    rst = 1'b1; A = 4'hF; B = 4'hF; boton = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_a", o_a, 4'h0);
      chk("rst_b", o_b, 4'h0);
      chk("rst_valid", {3'b0, valid}, 4'h0);
    end
    rst = 1'b0; boton = 1'b0; A = 4'h0; B = 4'h0;
    for (int i = 0; i < 4; i++) step();
    chk("idle_valid", {3'b0, valid}, 4'h0);

    // Basic capture: capture and valid at edge 4
    A = 4'b1011; B = 4'b0110; boton = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("basic_pre_valid", {3'b0, valid}, 4'h0);
      chk("basic_pre_a", o_a, 4'h0);
    end
    step();
    boton = 1'b0;
    seen = 1'b1;
    chk("basic_a", o_a, 4'b1011);
    chk("basic_b", o_b, 4'b0110);
    chk("basic_valid", {3'b0, valid}, 4'h1);
    step();
    chk("basic_valid_after", {3'b0, valid}, {3'b0, idle_v()});
    for (int i = 0; i < 5; i++) step();

    // Glitch: one cycle high only
    A = 4'h2; B = 4'h2; boton = 1'b1;
    step();
    boton = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("glitch_valid", {3'b0, valid}, {3'b0, idle_v()});
    end
    chk("glitch_a", o_a, 4'b1011);
    chk("glitch_b", o_b, 4'b0110);

    // Hold for 20 cycles, A changes after capture
    A = 4'h3; B = 4'h9; boton = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_pre_valid", {3'b0, valid}, {3'b0, idle_v()});
    end
    step();
    chk("hold_a", o_a, 4'h3);
    chk("hold_valid", {3'b0, valid}, 4'h1);
    A = 4'h5;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("hold_no_retrig", {3'b0, valid}, {3'b0, idle_v()});
    end
    chk("hold_a_kept", o_a, 4'h3);
    chk("hold_b_kept", o_b, 4'h9);
    boton = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Second press
    A = 4'b1000; B = 4'b0111; boton = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("second_pre_a", o_a, 4'h3);
    step();
    chk("second_a", o_a, 4'b1000);
    chk("second_b", o_b, 4'b0111);
    chk("second_valid", {3'b0, valid}, 4'h1);
    step();
    chk("second_valid_after", {3'b0, valid}, {3'b0, idle_v()});
    boton = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Reset at edge 3 of a held press
    boton = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    seen = 1'b0;
    chk("midrst_valid", {3'b0, valid}, 4'h0);
    chk("midrst_a", o_a, 4'h0);
    chk("midrst_b", o_b, 4'h0);
    rst = 1'b0; A = 4'h6; B = 4'hA;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("midrst_pre_valid", {3'b0, valid}, 4'h0);
      chk("midrst_pre_a", o_a, 4'h0);
    end
    step();
    seen = 1'b1;
    chk("midrst_cap_a", o_a, 4'h6);
    chk("midrst_cap_b", o_b, 4'hA);
    chk("midrst_cap_valid", {3'b0, valid}, 4'h1);
    step();
    chk("midrst_valid_after", {3'b0, valid}, {3'b0, idle_v()});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
